// File: rtl/alarm_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_pkg
//  Purpose  : Shared types and constants for the alarm sequencer.
//             - alarm_state_t : sequencer state encoding
//             - tmr_width()   : timer width able to hold max(a,b)-1
//             - TMR_W         : timer width at the default durations (9 bits)
//  Revision : 1.0  initial release
// ============================================================================
package alarm_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RING   = 2'd1,
        SNOOZE = 2'd2,
        DONE   = 2'd3
    } alarm_state_t;

    localparam int c_RING_SECS_DEF   = 60;
    localparam int c_SNOOZE_SECS_DEF = 300;

    // Width needed for a down-counter loaded with max(a,b)-1, never below 1.
    function automatic int tmr_width(input int a, input int b);
        int m;
        m = (a > b) ? a : b;
        return (m <= 2) ? 1 : $clog2(m);
    endfunction

    localparam int TMR_W = tmr_width(c_RING_SECS_DEF, c_SNOOZE_SECS_DEF);

endpackage
`default_nettype wire

// File: rtl/alarm_timer.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_timer
//  Purpose  : Loadable seconds down-counter, shared by the ring and snooze
//             durations. Load has priority over counting; counting happens
//             only on sec_tick and saturates at zero.
//  Ports    : clk, reset (sync, active-high), load, load_val[W-1:0],
//             sec_tick, zero (count == 0)
//  Revision : 1.0  initial release
// ============================================================================
module alarm_timer
    import alarm_pkg::*;
#(
    parameter int W = TMR_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         sec_tick,
    output logic         zero
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_val;
        end else if (sec_tick && (r_count != '0)) begin
            r_count <= r_count - 1'b1;
        end
    end

    assign zero = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : alarm_ctrl
//  Purpose  : Alarm sequencer. Turns the comparator's match level into a
//             bounded ring, snooze cycles and a stop/re-arm cycle, counting
//             on the 1 Hz sec_tick.
//  Ports    : clk, reset (sync, active-high), sec_tick, alarm_en, match,
//             snooze, stop  -> buzz, snoozing, snooze_cnt[1:0]
//  Options  : ALARM_PULSE_EN - when defined, buzz pulses 1 s on / 1 s off
//             during RING (starting on) instead of staying steady.
//  Revision : 1.0  initial release
// ============================================================================
module alarm_ctrl
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = c_RING_SECS_DEF,
    parameter int SNOOZE_SECS = c_SNOOZE_SECS_DEF,
    parameter int MAX_SNOOZES = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       sec_tick,
    input  logic       alarm_en,
    input  logic       match,
    input  logic       snooze,
    input  logic       stop,
    output logic       buzz,
    output logic       snoozing,
    output logic [1:0] snooze_cnt
);

    localparam int                 c_TMR_W       = tmr_width(RING_SECS, SNOOZE_SECS);
    localparam logic [c_TMR_W-1:0] c_RING_LOAD   = c_TMR_W'(RING_SECS - 1);
    localparam logic [c_TMR_W-1:0] c_SNOOZE_LOAD = c_TMR_W'(SNOOZE_SECS - 1);
    localparam logic [1:0]         c_MAX_SN      = 2'(MAX_SNOOZES);

    alarm_state_t       r_state;
    alarm_state_t       w_nxt;
    logic               r_match_q;
    logic               r_first;      // high only on the first cycle after reset
    logic [1:0]         r_cnt;
    logic [1:0]         w_cnt_nxt;
    logic               r_buzz;
    logic               w_buzz_nxt;
    logic               r_snoozing;
    logic               w_rise;
    logic               w_load;
    logic [c_TMR_W-1:0] w_load_val;
    logic               w_zero;

    // match_q is cleared by reset, so a match still high when reset releases
    // would look like a fresh edge. r_first masks that one cycle so a rise
    // needs match to go low and high again.
    assign w_rise = match & ~r_match_q & ~r_first;

    alarm_timer #(
        .W (c_TMR_W)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .sec_tick (sec_tick),
        .zero     (w_zero)
    );

    always_comb begin
        w_nxt      = r_state;
        w_cnt_nxt  = r_cnt;
        w_load     = 1'b0;
        w_load_val = c_RING_LOAD;
        if (!alarm_en) begin
            w_nxt     = IDLE;
            w_cnt_nxt = '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_rise) begin
                        w_nxt     = RING;
                        w_load    = 1'b1;
                        w_cnt_nxt = '0;
                    end
                end
                RING: begin
                    // stop beats snooze, snooze beats a simultaneous timeout
                    if (stop) begin
                        w_nxt = DONE;
                    end else if (snooze) begin
                        if (r_cnt < c_MAX_SN) begin
                            w_nxt      = SNOOZE;
                            w_load     = 1'b1;
                            w_load_val = c_SNOOZE_LOAD;
                            w_cnt_nxt  = r_cnt + 2'd1;
                        end else begin
                            w_nxt = DONE;
                        end
                    end else if (sec_tick && w_zero) begin
                        w_nxt = DONE;
                    end
                end
                SNOOZE: begin
                    if (stop) begin
                        w_nxt = DONE;
                    end else if (sec_tick && w_zero) begin
                        w_nxt  = RING;
                        w_load = 1'b1;
                    end
                end
                DONE: begin
                    // hold until the matching minute ends so it cannot retrigger
                    if (!match) begin
                        w_nxt = IDLE;
                    end
                end
                default: w_nxt = IDLE;
            endcase
        end
    end

`ifdef ALARM_PULSE_EN
    logic r_phase;
    logic w_phase_nxt;

    always_comb begin
        w_phase_nxt = r_phase;
        if ((w_nxt == RING) && (r_state != RING)) begin
            w_phase_nxt = 1'b1;
        end else if ((r_state == RING) && sec_tick) begin
            w_phase_nxt = ~r_phase;
        end
    end

    assign w_buzz_nxt = (w_nxt == RING) & w_phase_nxt;
`else
    assign w_buzz_nxt = (w_nxt == RING);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_match_q  <= 1'b0;
            r_first    <= 1'b1;
            r_cnt      <= '0;
            r_buzz     <= 1'b0;
            r_snoozing <= 1'b0;
`ifdef ALARM_PULSE_EN
            r_phase    <= 1'b0;
`endif
        end else begin
            r_state    <= w_nxt;
            r_match_q  <= match;
            r_first    <= 1'b0;
            r_cnt      <= w_cnt_nxt;
            r_buzz     <= w_buzz_nxt;
            r_snoozing <= (w_nxt == SNOOZE);
`ifdef ALARM_PULSE_EN
            r_phase    <= w_phase_nxt;
`endif
        end
    end

    assign buzz       = r_buzz;
    assign snoozing   = r_snoozing;
    assign snooze_cnt = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alarm_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_alarm_ctrl
//  Purpose  : Directed self-checking bench for alarm_ctrl at default
//             parameters (60 s ring, 300 s snooze, 3 snoozes).
//  Revision : 1.0  initial release
// ============================================================================
module tb_alarm_ctrl;

`ifdef ALARM_PULSE_EN
    localparam bit c_PULSE = 1'b1;
`else
    localparam bit c_PULSE = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sec_tick = 1'b0;
    logic       alarm_en = 1'b0;
    logic       match = 1'b0;
    logic       snooze = 1'b0;
    logic       stop = 1'b0;
    logic       buzz;
    logic       snoozing;
    logic [1:0] snooze_cnt;

    int checks   = 0;
    int failures = 0;

    alarm_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .sec_tick   (sec_tick),
        .alarm_en   (alarm_en),
        .match      (match),
        .snooze     (snooze),
        .stop       (stop),
        .buzz       (buzz),
        .snoozing   (snoozing),
        .snooze_cnt (snooze_cnt)
    );

    always #5 clk = ~clk;

    // inputs change and outputs are sampled 1 time unit after the rising edge
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sec_tick = 1'b1;
        clk1();
        sec_tick = 1'b0;
        clk1();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic press_snooze();
        snooze = 1'b1;
        clk1();
        snooze = 1'b0;
    endtask

    task automatic press_stop();
        stop = 1'b1;
        clk1();
        stop = 1'b0;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp)
        else begin
            failures++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_out(input string tag, input logic b, input logic s, input logic [1:0] c);
        check({tag, ".buzz"}, 32'(buzz), 32'(b));
        check({tag, ".snoozing"}, 32'(snoozing), 32'(s));
        check({tag, ".cnt"}, 32'(snooze_cnt), 32'(c));
    endtask

    initial begin
        // reset
        clk1(); clk1(); clk1();
        reset = 1'b0;
        clk1();
        check_out("reset", 1'b0, 1'b0, 2'd0);

        // 1: ring then auto-timeout after exactly 60 ticks
        alarm_en = 1'b1;
        clk1();
        match = 1'b1;
        clk1();
        check_out("t1_ring", 1'b1, 1'b0, 2'd0);
        ticks(59);
        check("t1_tick59_buzz", 32'(buzz), c_PULSE ? 32'd0 : 32'd1);
        tick();
        check("t1_timeout_buzz", 32'(buzz), 32'd0);
        ticks(3);
        check("t1_no_retrigger", 32'(buzz), 32'd0);
        match = 1'b0;
        clk1();
        clk1();
        check("t1_idle_buzz", 32'(buzz), 32'd0);

        // 2: snooze then re-ring with match already low
        match = 1'b1;
        clk1();
        check("t2_ring", 32'(buzz), 32'd1);
        ticks(5);
        press_snooze();
        check_out("t2_snooze", 1'b0, 1'b1, 2'd1);
        match = 1'b0;
        ticks(299);
        check_out("t2_tick299", 1'b0, 1'b1, 2'd1);
        press_snooze();
        check_out("t2_snooze_ignored", 1'b0, 1'b1, 2'd1);
        tick();
        check_out("t2_rering", 1'b1, 1'b0, 2'd1);
        press_stop();
        check_out("t2_stop", 1'b0, 1'b0, 2'd1);
        clk1();

        // 3: three snoozes, fourth acts as stop
        match = 1'b1;
        clk1();
        check_out("t3_ring", 1'b1, 1'b0, 2'd0);
        match = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            press_snooze();
            check_out("t3_snooze", 1'b0, 1'b1, 2'(i));
            ticks(300);
            check_out("t3_rering", 1'b1, 1'b0, 2'(i));
        end
        press_snooze();
        check_out("t3_fourth", 1'b0, 1'b0, 2'd3);
        ticks(310);
        check_out("t3_no_more", 1'b0, 1'b0, 2'd3);

        // 4: stop and snooze together during RING
        match = 1'b1;
        clk1();
        check_out("t4_ring", 1'b1, 1'b0, 2'd0);
        match = 1'b0;
        press_snooze();
        ticks(300);
        check_out("t4_rering", 1'b1, 1'b0, 2'd1);
        stop = 1'b1;
        snooze = 1'b1;
        clk1();
        stop = 1'b0;
        snooze = 1'b0;
        check_out("t4_stop_wins", 1'b0, 1'b0, 2'd1);
        clk1();

        // snooze in the same cycle as timeout: snooze wins
        match = 1'b1;
        clk1();
        check_out("tb_ring", 1'b1, 1'b0, 2'd0);
        ticks(59);
        sec_tick = 1'b1;
        snooze = 1'b1;
        clk1();
        sec_tick = 1'b0;
        snooze = 1'b0;
        check_out("tb_snooze_vs_timeout", 1'b0, 1'b1, 2'd1);
        press_stop();
        check_out("tb_stop_in_snooze", 1'b0, 1'b0, 2'd1);
        match = 1'b0;
        clk1();

        // 5: arming while match high does not ring; disarm mid-RING
        alarm_en = 1'b0;
        clk1();
        match = 1'b1;
        clk1();
        alarm_en = 1'b1;
        clk1(); clk1(); clk1();
        check("t5_arm_midminute", 32'(buzz), 32'd0);
        match = 1'b0;
        clk1();
        match = 1'b1;
        clk1();
        check("t5_ring", 32'(buzz), 32'd1);
        press_snooze();
        ticks(300);
        check_out("t5_rering", 1'b1, 1'b0, 2'd1);
        alarm_en = 1'b0;
        clk1();
        check_out("t5_disarm", 1'b0, 1'b0, 2'd0);
        alarm_en = 1'b1;

        // 6: reset mid-SNOOZE with match high
        match = 1'b0;
        clk1();
        match = 1'b1;
        clk1();
        check("t6_ring", 32'(buzz), 32'd1);
        press_snooze();
        check_out("t6_snooze", 1'b0, 1'b1, 2'd1);
        reset = 1'b1;
        clk1();
        check_out("t6_reset", 1'b0, 1'b0, 2'd0);
        reset = 1'b0;
        clk1(); clk1(); clk1();
        ticks(3);
        check_out("t6_no_ring_after_reset", 1'b0, 1'b0, 2'd0);
        match = 1'b0;
        clk1();
        match = 1'b1;
        clk1();
        check("t6_ring_again", 32'(buzz), 32'd1);
        tick();
        check("t6_pattern1", 32'(buzz), c_PULSE ? 32'd0 : 32'd1);
        tick();
        check("t6_pattern2", 32'(buzz), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
